// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the picorv32-native-bus initiator.
// Provides the FSM state enum, bus geometry and the default timeout length.
package mem_bus_pkg;

    localparam int unsigned WORD_BYTES         = 4;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned DATA_W             = 32;
    localparam int unsigned MAX_LEN_DEF        = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGap,
        StRsp
    } state_e;

    function automatic logic is_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Command, response and picorv32 native memory bus signals of mem_initiator.
// The master modport is the initiator side; slave is the agent/responder side.
interface mem_initiator_if #(
    parameter int unsigned MAX_LEN = mem_bus_pkg::MAX_LEN_DEF
) ();
    import mem_bus_pkg::*;

    localparam int unsigned LEN_W = $clog2(MAX_LEN);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_last;

    logic              mem_valid;
    logic              mem_instr;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_last,
        input  rsp_ready,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
        output rsp_ready,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_initiator.sv
// Turns one command into 1..MAX_LEN incrementing word beats on the picorv32 native bus.
// Define MEM_INITIATOR_TIMEOUT_EN to abort a beat whose mem_ready never arrives.
module mem_initiator
    import mem_bus_pkg::*;
#(
`ifdef MEM_INITIATOR_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    mem_initiator_if.master bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              last_q, last_d;

`ifdef MEM_INITIATOR_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // Counts REQ cycles; restarts from zero on every new beat.
    assign tmo_d   = (state_q == StReq) ? tmo_q + TMO_W'(1) : '0;
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        len_d   = len_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        last_d  = last_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    len_d   = bus.cmd_len;
                    beat_d  = '0;
                    addr_d  = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = bus.cmd_wdata;
                    wstrb_d = bus.cmd_write ? bus.cmd_wstrb : 4'b0000;
                    if (is_aligned(bus.cmd_addr[1:0])) begin
                        state_d = StReq;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        last_d  = 1'b1;
                        state_d = StRsp;
                    end
                end
            end
            StReq: begin
                // mem_ready wins over a timeout expiring in the same cycle.
                if (bus.mem_ready) begin
                    rdata_d = write_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    last_d  = (beat_q == len_q);
                    state_d = StRsp;
                end
`ifdef MEM_INITIATOR_TIMEOUT_EN
                else if (tmo_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    last_d  = 1'b1;
                    state_d = StRsp;
                end
`endif
            end
            StGap: begin
                state_d = StReq;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    if (last_q || err_q) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                        beat_d  = beat_q + LEN_W'(1);
                        state_d = StGap;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.mem_valid = (state_q == StReq);
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.rsp_valid = (state_q == StRsp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_last  = last_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a transaction-level model predicts every bus request
// and every response; a negedge monitor compares the DUT against it each cycle.
module tb_mem_initiator;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    mem_initiator_if bus ();

`ifdef MEM_INITIATOR_TIMEOUT_EN
    mem_initiator #(.TIMEOUT_CYCLES(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));
`else
    mem_initiator dut (.clk(clk), .resetn(resetn), .bus(bus));
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          wr;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          last;
    } rsp_t;

    int total = 0;
    int bad = 0;

    bus_t        exp_bus[$];
    rsp_t        exp_rsp[$];
    int          bus_rd = 0;
    int          rsp_rd = 0;
    logic [31:0] obs_addr[$];

    int          hs_total = 0;
    logic [31:0] last_rdata = '0;
    bit          last_err = 1'b0;
    bit          last_last = 1'b0;
    int          last_vcnt = 0;
    int          max_stall = 0;

    bit silent = 1'b0;
    int resp_lat = 0;
    int stray_req = 0;
    int stall_beat = -1;
    int stall_len = 0;
    int stall_used = 0;

    // Memory contents seen by the responder.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Responder: answers resp_lat cycles after mem_valid rises, unless silent.
    initial begin : responder
        int wcnt;
        int stray_done;
        wcnt = 0;
        stray_done = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_0000;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hBAD0_0000;
                wcnt = 0;
            end else if (stray_done != stray_req && !bus.mem_valid) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h5555_AAAA;
                stray_done++;
            end else if (bus.mem_valid && !silent) begin
                if (wcnt >= resp_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mdata(bus.mem_addr);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Response sink: ready by default, withholds ready on a chosen beat.
    initial begin : sink
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid && hs_total == stall_beat && stall_used < stall_len) begin
                bus.rsp_ready = 1'b0;
                stall_used++;
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    initial begin : monitor
        bit          p_mv, p_acc, p_al, p_done, p_rv, p_hs;
        bit          p_err, p_last;
        logic [31:0] p_addr, p_rdata;
        int          gap, vcnt, stall;
        p_mv = 0; p_acc = 0; p_al = 0; p_done = 0; p_rv = 0; p_hs = 0;
        p_err = 0; p_last = 0; p_addr = '0; p_rdata = '0;
        gap = 0; vcnt = 0; stall = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
                chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                p_mv = 0; p_acc = 0; p_done = 0; p_rv = 0; p_hs = 0;
                gap = 0; vcnt = 0; stall = 0;
            end else begin
                if (p_acc) begin
                    if (p_al) chk("accept_to_mem_valid", 32'(bus.mem_valid), 32'd1);
                    else      chk("misaligned_to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                end
                if (p_done) begin
                    chk("ready_to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                    chk("ready_drops_mem_valid", 32'(bus.mem_valid), 32'd0);
                end
                if (gap == 1) begin
                    chk("gap_cycle_idle", 32'(bus.mem_valid), 32'd0);
                    gap = 2;
                end else if (gap == 2) begin
                    chk("gap_then_req", 32'(bus.mem_valid), 32'd1);
                    gap = 0;
                end
                if (bus.mem_valid || bus.rsp_valid)
                    chk("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
                if (bus.rsp_valid)
                    chk("no_req_during_rsp", 32'(bus.mem_valid), 32'd0);

                if (bus.mem_valid && !p_mv) begin
                    obs_addr.push_back(bus.mem_addr);
                    if (bus_rd >= exp_bus.size()) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got addr %h want no request", bus.mem_addr);
                    end else begin
                        chk("req_addr", bus.mem_addr, exp_bus[bus_rd].addr);
                        chk("req_wstrb", 32'(bus.mem_wstrb), 32'(exp_bus[bus_rd].wstrb));
                        if (exp_bus[bus_rd].wr)
                            chk("req_wdata", bus.mem_wdata, exp_bus[bus_rd].wdata);
                        bus_rd++;
                    end
                    vcnt = 0;
                end
                if (bus.mem_valid) begin
                    if (p_mv) chk("req_addr_stable", bus.mem_addr, p_addr);
                    vcnt++;
                end else if (p_mv) begin
                    last_vcnt = vcnt;
                end

                if (bus.rsp_valid) begin
                    if (p_rv && !p_hs) begin
                        chk("rsp_rdata_stable", bus.rsp_rdata, p_rdata);
                        chk("rsp_err_stable", 32'(bus.rsp_err), 32'(p_err));
                        chk("rsp_last_stable", 32'(bus.rsp_last), 32'(p_last));
                    end
                    if (!bus.rsp_ready) begin
                        stall++;
                    end else begin
                        if (stall > max_stall) max_stall = stall;
                        stall = 0;
                        if (rsp_rd >= exp_rsp.size()) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_rsp: got rdata %h want no response",
                                     bus.rsp_rdata);
                        end else begin
                            chk("rsp_rdata", bus.rsp_rdata, exp_rsp[rsp_rd].rdata);
                            chk("rsp_err", 32'(bus.rsp_err), 32'(exp_rsp[rsp_rd].err));
                            chk("rsp_last", 32'(bus.rsp_last), 32'(exp_rsp[rsp_rd].last));
                            if (!exp_rsp[rsp_rd].last && !exp_rsp[rsp_rd].err) gap = 1;
                            rsp_rd++;
                        end
                        last_rdata = bus.rsp_rdata;
                        last_err   = bus.rsp_err;
                        last_last  = bus.rsp_last;
                        hs_total++;
                    end
                end
                p_mv    = bus.mem_valid;
                p_acc   = bus.cmd_valid && bus.cmd_ready;
                p_al    = (bus.cmd_addr[1:0] == 2'b00);
                p_done  = bus.mem_valid && bus.mem_ready;
                p_rv    = bus.rsp_valid;
                p_hs    = bus.rsp_valid && bus.rsp_ready;
                p_addr  = bus.mem_addr;
                p_rdata = bus.rsp_rdata;
                p_err   = bus.rsp_err;
                p_last  = bus.rsp_last;
            end
        end
    end

    // mode 0: normal, 1: first beat times out, 2: first beat aborted by reset (no response)
    task automatic issue(input bit wr, input logic [31:0] a, input logic [3:0] len,
                         input logic [31:0] wd, input logic [3:0] ws, input int mode);
        rsp_t        r;
        bus_t        b;
        logic [31:0] ba;
        int          n;
        if (a[1:0] != 2'b00) begin
            r.rdata = '0; r.err = 1'b1; r.last = 1'b1;
            exp_rsp.push_back(r);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                ba = a + 32'(4 * i);
                b.addr = ba; b.wdata = wd; b.wstrb = wr ? ws : 4'h0; b.wr = wr;
                exp_bus.push_back(b);
                if (mode == 2) break;
                if (mode == 1) begin
                    r.rdata = '0; r.err = 1'b1; r.last = 1'b1;
                    exp_rsp.push_back(r);
                    break;
                end
                r.rdata = wr ? 32'd0 : mdata(ba);
                r.err   = 1'b0;
                r.last  = (i == int'(len));
                exp_rsp.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = len;
        bus.cmd_wdata = wd;
        bus.cmd_wstrb = ws;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cmd_accept_in_time", 32'(n < 100), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = 32'hFFFF_0001;
        bus.cmd_len   = 4'hF;
        bus.cmd_wdata = 32'h0BAD_F00D;
        bus.cmd_wstrb = 4'h0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((rsp_rd < exp_rsp.size() || !bus.cmd_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 400), 32'd1);
        @(negedge clk);
        chk("all_requests_seen", 32'(bus_rd), 32'(exp_bus.size()));
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_mem_valid_out", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_instr", 32'(bus.mem_instr), 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rsp_valid_out", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    endtask

    initial begin : main
        int          o, h, n;
        logic [31:0] wr_addrs[4];
        logic [31:0] wrap_addrs[3];
        wr_addrs   = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
        wrap_addrs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check_reset_vals();

        // Single read, 1-cycle responder
        o = obs_addr.size();
        h = hs_total;
        issue(1'b0, 32'h0000_0010, 4'd0, 32'h0, 4'hF, 0);
        wait_done("single_read_done");
        chk("single_rdata", last_rdata, 32'hDEAD_BEEF);
        chk("single_err", 32'(last_err), 32'd0);
        chk("single_last", 32'(last_last), 32'd1);
        chk("single_beats", 32'(hs_total - h), 32'd1);
        chk("single_reqs", 32'(obs_addr.size() - o), 32'd1);
        if (obs_addr.size() > o) chk("single_addr", obs_addr[o], 32'h0000_0010);

        // Write burst of 4 beats
        o = obs_addr.size();
        h = hs_total;
        issue(1'b1, 32'h0000_0100, 4'd3, 32'h1234_5678, 4'hF, 0);
        wait_done("write_burst_done");
        chk("write_beats", 32'(hs_total - h), 32'd4);
        chk("write_reqs", 32'(obs_addr.size() - o), 32'd4);
        for (int i = 0; i < 4; i++)
            if (obs_addr.size() > o + i) chk("write_addr", obs_addr[o + i], wr_addrs[i]);
        chk("write_rdata_zero", last_rdata, 32'd0);

        // Address wrap with a slower responder
        resp_lat = 2;
        o = obs_addr.size();
        issue(1'b0, 32'hFFFF_FFF8, 4'd2, 32'h0, 4'h0, 0);
        wait_done("wrap_done");
        resp_lat = 0;
        chk("wrap_reqs", 32'(obs_addr.size() - o), 32'd3);
        for (int i = 0; i < 3; i++)
            if (obs_addr.size() > o + i) chk("wrap_addr", obs_addr[o + i], wrap_addrs[i]);
        chk("wrap_last_rdata", last_rdata, 32'h0000_FFFF);

        // Misaligned read and misaligned multi-beat write
        o = obs_addr.size();
        h = hs_total;
        issue(1'b0, 32'h0000_0002, 4'd0, 32'h0, 4'h0, 0);
        wait_done("misaligned_done");
        chk("misaligned_rdata", last_rdata, 32'd0);
        chk("misaligned_err", 32'(last_err), 32'd1);
        chk("misaligned_last", 32'(last_last), 32'd1);
        issue(1'b1, 32'h0000_0107, 4'd3, 32'hCAFE_F00D, 4'h3, 0);
        wait_done("misaligned_wr_done");
        chk("misaligned_no_reqs", 32'(obs_addr.size() - o), 32'd0);
        chk("misaligned_beats", 32'(hs_total - h), 32'd2);

        // Stray mem_ready while idle
        h = hs_total;
        stray_req++;
        repeat (4) @(negedge clk);
        chk("stray_no_rsp", 32'(hs_total - h), 32'd0);
        chk("stray_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stray_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Back-pressure: hold rsp_ready low 10 cycles on the second beat
        h = hs_total;
        stall_beat = hs_total + 1;
        stall_len  = stall_used + 10;
        issue(1'b0, 32'h0000_0200, 4'd3, 32'h0, 4'h0, 0);
        wait_done("stall_done");
        chk("stall_cycles", 32'(max_stall), 32'd10);
        chk("stall_beats", 32'(hs_total - h), 32'd4);
        chk("stall_last_rdata", last_rdata, 32'h020C_FDF3);

`ifdef MEM_INITIATOR_TIMEOUT_EN
        // Silent responder: beat must time out after 8 cycles
        silent = 1'b1;
        issue(1'b0, 32'h0000_0300, 4'd1, 32'h0, 4'h0, 1);
        wait_done("timeout_done");
        silent = 1'b0;
        chk("timeout_valid_cycles", 32'(last_vcnt), 32'd8);
        chk("timeout_err", 32'(last_err), 32'd1);
        chk("timeout_last", 32'(last_last), 32'd1);
        chk("timeout_rdata", last_rdata, 32'd0);
`endif

        // Reset in the middle of a request
        silent = 1'b1;
        h = hs_total;
        issue(1'b0, 32'h0000_0400, 4'd2, 32'h0, 4'h0, 2);
        n = 0;
        while (!bus.mem_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_req_seen", 32'(bus.mem_valid), 32'd1);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort_mem_valid_drop", 32'(bus.mem_valid), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        silent = 1'b0;
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        check_reset_vals();
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        chk("abort_hs_count", 32'(hs_total - h), 32'd0);
        chk("final_requests_seen", 32'(bus_rd), 32'(exp_bus.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
